// File: rtl/dds_sweep_pkg.sv
// Shared types and default widths for the DDS frequency-sweep controller.
package dds_sweep_pkg;

  localparam int PHASE_W_DEF = 10;
  localparam int STEP_W_DEF  = 4;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    DWELL = 2'b10,
    DONE  = 2'b11
  } sweep_state_t;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_CONT = 2'b10
  } sweep_mode_t;

  // Map the raw 2-bit mode field onto the enum; the unused code 11 runs as a single up sweep.
  function automatic sweep_mode_t decode_mode(input logic [1:0] raw);
    sweep_mode_t m;
    case (raw)
      2'b01:   m = MODE_DOWN;
      2'b10:   m = MODE_CONT;
      default: m = MODE_UP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that times how long each step value is held.
// The count is the number of enabled cycles still remaining in the current
// hold, including the present one, so expire marks the final enabled cycle.
module dds_dwell_timer
  import dds_sweep_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expire
);

  localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  logic [DWELL_W-1:0] count_r;

  // Reload on request, otherwise count down on enabled cycles and rest at one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {DWELL_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r > CNT_ONE)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == CNT_ONE);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller driving dds_en / step / phase_start of the DDS core.
// Optional build macro: DDS_SWEEP_PAUSE_EN adds a pause input that freezes the
// current hold (dds_en low, step and dwell count frozen) while asserted in DWELL.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int STEP_W  = STEP_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
`ifdef DDS_SWEEP_PAUSE_EN
  input  logic               pause,
`endif
  input  logic [1:0]         mode,
  input  logic [STEP_W-1:0]  step_min,
  input  logic [STEP_W-1:0]  step_max,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [PHASE_W-1:0] phase_start_in,
  output logic               dds_en,
  output logic [STEP_W-1:0]  step,
  output logic [PHASE_W-1:0] phase_start,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [STEP_W-1:0]  STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  sweep_state_t       state_r, state_s;
  sweep_mode_t        mode_r, mode_in_s;
  logic [STEP_W-1:0]  min_r, max_r, step_r, step_s;
  logic [DWELL_W-1:0] dwell_r, dwell_eff_s, tmr_load_val_s;
  logic [PHASE_W-1:0] phase_r;
  logic               dir_up_r, dir_up_s;
  logic               dds_en_r, busy_r, done_r, cfg_err_r, cfg_err_s;
  logic               load_cfg_s, tmr_load_s, tmr_expire_s, hold_end_s, pause_s;

`ifdef DDS_SWEEP_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign mode_in_s   = decode_mode(mode);
  assign dwell_eff_s = (dwell_cycles == {DWELL_W{1'b0}}) ? DWELL_ONE : dwell_cycles;
  // Only cycles actually shown to the DDS (dds_en high) count toward a hold.
  assign hold_end_s  = dds_en_r && tmr_expire_s;

  dds_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .en       (dds_en_r),
    .load_val (tmr_load_val_s),
    .expire   (tmr_expire_s)
  );

  // Next-state, step walk, direction and error decisions.
  always_comb begin
    state_s        = state_r;
    step_s         = step_r;
    dir_up_s       = dir_up_r;
    cfg_err_s      = cfg_err_r;
    load_cfg_s     = 1'b0;
    tmr_load_s     = 1'b0;
    tmr_load_val_s = dwell_r;
    case (state_r)
      IDLE: begin
        if (abort) begin
          state_s = IDLE;
        end else if (start) begin
          state_s   = LOAD;
          cfg_err_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_s = IDLE;
        end else begin
          load_cfg_s = 1'b1;
          dir_up_s   = 1'b1;
          step_s     = (mode_in_s == MODE_DOWN) ? step_max : step_min;
          if (step_min > step_max) begin
            cfg_err_s = 1'b1;
            state_s   = DONE;
          end else begin
            state_s        = DWELL;
            tmr_load_s     = 1'b1;
            tmr_load_val_s = dwell_eff_s;
          end
        end
      end
      DWELL: begin
        if (abort) begin
          state_s = IDLE;
        end else if (hold_end_s) begin
          case (mode_r)
            MODE_DOWN: begin
              if (step_r == min_r) begin
                state_s = DONE;
              end else begin
                step_s     = step_r - STEP_ONE;
                tmr_load_s = 1'b1;
              end
            end
            MODE_CONT: begin
              tmr_load_s = 1'b1;
              if (min_r == max_r) begin
                step_s = step_r;
              end else if (dir_up_r) begin
                if (step_r == max_r) begin
                  dir_up_s = 1'b0;
                  step_s   = step_r - STEP_ONE;
                end else begin
                  step_s = step_r + STEP_ONE;
                end
              end else begin
                if (step_r == min_r) begin
                  dir_up_s = 1'b1;
                  step_s   = step_r + STEP_ONE;
                end else begin
                  step_s = step_r - STEP_ONE;
                end
              end
            end
            default: begin
              if (step_r == max_r) begin
                state_s = DONE;
              end else begin
                step_s     = step_r + STEP_ONE;
                tmr_load_s = 1'b1;
              end
            end
          endcase
        end else begin
          state_s = DWELL;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, step and registered handshake outputs, all derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      step_r    <= {STEP_W{1'b0}};
      dir_up_r  <= 1'b1;
      cfg_err_r <= 1'b0;
      dds_en_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      step_r    <= step_s;
      dir_up_r  <= dir_up_s;
      cfg_err_r <= cfg_err_s;
      dds_en_r  <= (state_s == DWELL) && !pause_s;
      busy_r    <= (state_s == LOAD) || (state_s == DWELL);
      done_r    <= (state_s == DONE);
    end
  end

  // Sweep configuration captured in LOAD so later input changes cannot disturb a sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_r  <= MODE_UP;
      min_r   <= {STEP_W{1'b0}};
      max_r   <= {STEP_W{1'b0}};
      dwell_r <= DWELL_ONE;
      phase_r <= {PHASE_W{1'b0}};
    end else if (load_cfg_s) begin
      mode_r  <= mode_in_s;
      min_r   <= step_min;
      max_r   <= step_max;
      dwell_r <= dwell_eff_s;
      phase_r <= phase_start_in;
    end else begin
      mode_r  <= mode_r;
      min_r   <= min_r;
      max_r   <= max_r;
      dwell_r <= dwell_r;
      phase_r <= phase_r;
    end
  end

  assign dds_en      = dds_en_r;
  assign step        = step_r;
  assign phase_start = phase_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl. Cycle numbering: the cycle
// in which start is driven is cycle 0, so LOAD is cycle 1 and DWELL begins at 2.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
`ifdef DDS_SWEEP_PAUSE_EN
  logic        pause;
`endif
  logic [1:0]  mode;
  logic [3:0]  step_min;
  logic [3:0]  step_max;
  logic [15:0] dwell_cycles;
  logic [9:0]  phase_start_in;
  logic        dds_en;
  logic [3:0]  step;
  logic [9:0]  phase_start;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  dds_sweep_ctrl #(
    .PHASE_W (10),
    .STEP_W  (4),
    .DWELL_W (16)
  ) dut (
`ifdef DDS_SWEEP_PAUSE_EN
    .pause          (pause),
`endif
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .step_min       (step_min),
    .step_max       (step_max),
    .dwell_cycles   (dwell_cycles),
    .phase_start_in (phase_start_in),
    .dds_en         (dds_en),
    .step           (step),
    .phase_start    (phase_start),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [1:0] m, input logic [3:0] mn, input logic [3:0] mx,
                             input logic [15:0] dw, input logic [9:0] ph);
    mode           = m;
    step_min       = mn;
    step_max       = mx;
    dwell_cycles   = dw;
    phase_start_in = ph;
    start          = 1'b1;
    tick();
    start          = 1'b0;
  endtask

  initial begin
    int en_cnt;
    int done_cnt;
    logic [3:0] cont_exp [0:10];
    cont_exp = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1};

    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00;
    step_min = 4'd0; step_max = 4'd0; dwell_cycles = 16'd0; phase_start_in = 10'd0;
`ifdef DDS_SWEEP_PAUSE_EN
    pause = 1'b0;
`endif

    // Reset state
    #12;
    check_eq("rst_dds_en", {31'd0, dds_en}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check_eq("rst_step", {28'd0, step}, 32'd0);
    check_eq("rst_phase", {22'd0, phase_start}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    // Single up 2..5, dwell 3; a start pulse mid-sweep with another mode must be ignored
    start_sweep(2'b00, 4'd2, 4'd5, 16'd3, 10'h2A5);
    for (int c = 1; c <= 16; c++) begin
      check_eq($sformatf("up_en c%0d", c), {31'd0, dds_en}, {31'd0, (c >= 2 && c <= 13)});
      check_eq($sformatf("up_busy c%0d", c), {31'd0, busy}, {31'd0, (c >= 1 && c <= 13)});
      check_eq($sformatf("up_done c%0d", c), {31'd0, done}, {31'd0, (c == 14)});
      if (c >= 2 && c <= 13) begin
        check_eq($sformatf("up_step c%0d", c), {28'd0, step}, 32'(2 + (c - 2) / 3));
      end else begin
        check_eq($sformatf("up_noen c%0d", c), {31'd0, dds_en}, 32'd0);
      end
      if (c == 2) check_eq("up_phase", {22'd0, phase_start}, 32'h2A5);
      if (c == 5) begin start = 1'b1; mode = 2'b01; end
      else if (c == 6) begin start = 1'b0; mode = 2'b00; end
      else begin start = 1'b0; end
      tick();
    end

    // Single down 3..1, dwell 0 treated as 1
    start_sweep(2'b01, 4'd1, 4'd3, 16'd0, 10'h011);
    en_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      if (dds_en) en_cnt++;
      if (done) done_cnt++;
      if (c >= 2 && c <= 4) check_eq($sformatf("dn_step c%0d", c), {28'd0, step}, 32'(5 - c));
      if (c == 5) check_eq("dn_done_c5", {31'd0, done}, 32'd1);
      tick();
    end
    check_eq("dn_en_count", 32'(en_cnt), 32'd3);
    check_eq("dn_done_count", 32'(done_cnt), 32'd1);

    // Continuous 0..2, dwell 2, abort during cycle 12
    start_sweep(2'b10, 4'd0, 4'd2, 16'd2, 10'h3FF);
    done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done) done_cnt++;
      if (c >= 2) begin
        check_eq($sformatf("cont_step c%0d", c), {28'd0, step}, {28'd0, cont_exp[c-2]});
        check_eq($sformatf("cont_en c%0d", c), {31'd0, dds_en}, 32'd1);
      end
      if (c == 12) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    check_eq("abort_en", {31'd0, dds_en}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_step_hold", {28'd0, step}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      if (done) done_cnt++;
      tick();
    end
    check_eq("cont_no_done", 32'(done_cnt), 32'd0);

    // Bad configuration min > max
    start_sweep(2'b00, 4'd7, 4'd3, 16'd3, 10'h000);
    en_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      if (dds_en) en_cnt++;
      if (c == 2) begin
        check_eq("bad_done", {31'd0, done}, 32'd1);
        check_eq("bad_cfg_err", {31'd0, cfg_err}, 32'd1);
        check_eq("bad_busy", {31'd0, busy}, 32'd0);
      end
      tick();
    end
    check_eq("bad_no_en", 32'(en_cnt), 32'd0);
    check_eq("bad_cfg_err_sticky", {31'd0, cfg_err}, 32'd1);

    // Valid start clears cfg_err; min == max single sweep is one hold
    start_sweep(2'b00, 4'd4, 4'd4, 16'd1, 10'h000);
    check_eq("clr_cfg_err", {31'd0, cfg_err}, 32'd0);
    tick();
    check_eq("eq_en", {31'd0, dds_en}, 32'd1);
    check_eq("eq_step", {28'd0, step}, 32'd4);
    tick();
    check_eq("eq_done", {31'd0, done}, 32'd1);
    check_eq("eq_en_off", {31'd0, dds_en}, 32'd0);
    tick();

    // Reset asserted mid-DWELL clears outputs asynchronously
    start_sweep(2'b00, 4'd0, 4'd9, 16'd5, 10'h155);
    tick(); tick(); tick();
    check_eq("pre_rst_en", {31'd0, dds_en}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_en", {31'd0, dds_en}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_step", {28'd0, step}, 32'd0);
    check_eq("mid_rst_phase", {22'd0, phase_start}, 32'd0);
    tick();
    reset = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) done_cnt++;
      tick();
    end
    check_eq("rst_no_done", 32'(done_cnt), 32'd0);

`ifdef DDS_SWEEP_PAUSE_EN
    // Pause for 5 cycles after the second hold cycle of step 1 (dwell 4)
    start_sweep(2'b00, 4'd1, 4'd2, 16'd4, 10'h000);
    for (int c = 1; c <= 16; c++) begin
      check_eq($sformatf("pz_en c%0d", c), {31'd0, dds_en},
               {31'd0, ((c >= 2 && c <= 3) || (c >= 9 && c <= 14))});
      check_eq($sformatf("pz_busy c%0d", c), {31'd0, busy}, {31'd0, (c >= 1 && c <= 14)});
      check_eq($sformatf("pz_done c%0d", c), {31'd0, done}, {31'd0, (c == 15)});
      if (c >= 2 && c <= 14) begin
        check_eq($sformatf("pz_step c%0d", c), {28'd0, step}, (c <= 10) ? 32'd1 : 32'd2);
      end
      if (c == 3) pause = 1'b1;
      if (c == 8) pause = 1'b0;
      tick();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
